parking_slot_table: RTL and testbench

//  Parametrised check-in/check-out table for N parking slots. Per slot it holds
//  an occupied flag and the check-in timestamp. On a press edge it checks in a

---
 rtl/park_pkg.sv | 20 ++
 rtl/slot_find_free.sv | 27 ++
 rtl/parking_slot_table.sv | 208 ++++++++++++++++++++
 tb/tb_parking_slot_table.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/park_pkg.sv
// Shared definitions for the parking slot table and its helpers.
//   mode_e : command encodings carried on the 2-bit mode input
//   err_e  : reject reasons reported on err_code
package park_pkg;

  typedef enum logic [1:0] {
    MODE_CHECKIN  = 2'd0,
    MODE_CHECKOUT = 2'd1,
    MODE_AUTO     = 2'd2,
    MODE_QUERY    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ERR_RANGE    = 2'd0,
    ERR_OCCUPIED = 2'd1,
    ERR_VACANT   = 2'd2,
    ERR_FULL     = 2'd3
  } err_e;

endpackage : park_pkg

// File: rtl/slot_find_free.sv
// Combinational priority encoder: finds the lowest-index vacant slot.
// Ports:
//   occupied  in  N_SLOTS  bit k-1 set = slot k occupied
//   free_idx  out SEL_W    1-based index of lowest vacant slot (0 if none)
//   any_free  out 1        at least one slot is vacant
module slot_find_free #(
  parameter int N_SLOTS = 6,
  parameter int SEL_W   = 4
) (
  input  logic [N_SLOTS-1:0] occupied,
  output logic [SEL_W-1:0]   free_idx,
  output logic               any_free
);

  // Scan from the top down so the lowest vacant index is the last one written.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!occupied[i]) begin
        free_idx = SEL_W'(i + 1);
        any_free = 1'b1;
      end
    end
  end

endmodule : slot_find_free

// File: rtl/parking_slot_table.sv
// Check-in/check-out table for N_SLOTS parking slots.
// Each slot stores an occupied flag and its check-in timestamp. A rising edge
// on press (while enable is high) executes one command; results appear one
// cycle later together with a single-cycle done or err pulse.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   enable       command gate
//   press        command strobe (rising edge = command)
//   mode         0 CHECKIN, 1 CHECKOUT, 2 CHECKIN_AUTO, 3 QUERY
//   selector     1-based target slot (ignored for CHECKIN_AUTO)
//   timer        free-running time base
//   p_time       packed check-in times, slot k at [(k-1)*TW +: TW]
//   occupied     per-slot occupied flags
//   free_count   number of vacant slots
//   done / err   single-cycle accept / reject pulses
//   err_code     reject reason, held until the next done/err
//   slot_out     slot acted on, held until the next done/err
//   duration     elapsed time from CHECKOUT/QUERY, held until updated
module parking_slot_table
  import park_pkg::*;
#(
  parameter int N_SLOTS = 6,
  parameter int TW      = 11,
  parameter int SEL_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  press,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      selector,
  input  logic [TW-1:0]         timer,
  output logic [N_SLOTS*TW-1:0] p_time,
  output logic [N_SLOTS-1:0]    occupied,
  output logic [SEL_W-1:0]      free_count,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [SEL_W-1:0]      slot_out,
  output logic [TW-1:0]         duration
);

  // Per-slot storage
  logic [N_SLOTS-1:0] occ_q;
  logic [TW-1:0]      ptime_q [N_SLOTS];

  // Per-slot write strobes produced by the command decoder
  logic [N_SLOTS-1:0] set_vec;
  logic [N_SLOTS-1:0] clr_vec;

  // Command / result registers
  logic               press_q;
  logic               done_q,     done_d;
  logic               err_q,      err_d;
  err_e               err_code_q, err_code_d;
  logic [SEL_W-1:0]   slot_out_q, slot_out_d;
  logic [TW-1:0]      duration_q, duration_d;

  // Decode helpers
  logic               cmd;
  logic [N_SLOTS-1:0] sel_hit;
  logic [N_SLOTS-1:0] auto_hit;
  logic               sel_ok;
  logic               cur_occ;
  logic [TW-1:0]      cur_ptime;
  logic [SEL_W-1:0]   free_idx;
  logic               any_free;
  logic [SEL_W-1:0]   occ_count;

  assign cmd = press & ~press_q & enable;

  slot_find_free #(
    .N_SLOTS (N_SLOTS),
    .SEL_W   (SEL_W)
  ) u_find_free (
    .occupied (occ_q),
    .free_idx (free_idx),
    .any_free (any_free)
  );

  // One-hot slot matches. An out-of-range selector matches no slot, which
  // doubles as the range check without needing a wide comparator.
  genvar gi;
  generate
    for (gi = 0; gi < N_SLOTS; gi++) begin : g_slot
      assign sel_hit[gi]  = (selector == SEL_W'(gi + 1));
      assign auto_hit[gi] = (free_idx == SEL_W'(gi + 1));

      always_ff @(posedge clk) begin
        if (reset) begin
          occ_q[gi]   <= 1'b0;
          ptime_q[gi] <= '0;
        end else if (set_vec[gi]) begin
          occ_q[gi]   <= 1'b1;
          ptime_q[gi] <= timer;
        end else if (clr_vec[gi]) begin
          occ_q[gi]   <= 1'b0;
          ptime_q[gi] <= '0;
        end
      end

      assign p_time[gi*TW +: TW] = ptime_q[gi];
    end
  endgenerate

  assign sel_ok  = |sel_hit;
  assign cur_occ = |(occ_q & sel_hit);

  // Timestamp of the selected slot (AND-OR mux over the one-hot match).
  always_comb begin
    cur_ptime = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (sel_hit[i]) cur_ptime = cur_ptime | ptime_q[i];
    end
  end

  always_comb begin
    occ_count = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      occ_count = occ_count + SEL_W'(occ_q[i]);
    end
  end

  // Command decoder: all effects are registered, so done/err and the state
  // change land in the same cycle.
  always_comb begin
    set_vec    = '0;
    clr_vec    = '0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    slot_out_d = slot_out_q;
    duration_d = duration_q;

    if (cmd) begin
      if (mode_e'(mode) == MODE_AUTO) begin
        if (any_free) begin
          set_vec    = auto_hit;
          done_d     = 1'b1;
          slot_out_d = free_idx;
        end else begin
          err_d      = 1'b1;
          err_code_d = ERR_FULL;
          slot_out_d = '0;
        end
      end else if (!sel_ok) begin
        err_d      = 1'b1;
        err_code_d = ERR_RANGE;
        slot_out_d = selector;
      end else begin
        slot_out_d = selector;
        unique case (mode_e'(mode))
          MODE_CHECKIN: begin
            if (cur_occ) begin
              err_d      = 1'b1;
              err_code_d = ERR_OCCUPIED;
            end else begin
              set_vec = sel_hit;
              done_d  = 1'b1;
            end
          end
          MODE_CHECKOUT, MODE_QUERY: begin
            if (!cur_occ) begin
              err_d      = 1'b1;
              err_code_d = ERR_VACANT;
            end else begin
              // Modulo-2^TW subtraction handles a timer wrap during the stay.
              duration_d = timer - cur_ptime;
              done_d     = 1'b1;
              if (mode_e'(mode) == MODE_CHECKOUT) clr_vec = sel_hit;
            end
          end
          default: begin
            err_d = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // History set to 1 so a press held through reset is not seen as an edge.
      press_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_RANGE;
      slot_out_q <= '0;
      duration_q <= '0;
    end else begin
      press_q    <= press;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      slot_out_q <= slot_out_d;
      duration_q <= duration_d;
    end
  end

  assign occupied   = occ_q;
  assign free_count = SEL_W'(N_SLOTS) - occ_count;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign slot_out   = slot_out_q;
  assign duration   = duration_q;

endmodule : parking_slot_table

// File: tb/tb_parking_slot_table.sv
// Self-checking bench for parking_slot_table (N_SLOTS=6, TW=11).
// A behavioural model (plain arrays) tracks the table and the expected
// result of every command; directed scenarios are followed by random traffic.
module tb_parking_slot_table;

  localparam int N  = 6;
  localparam int TW = 11;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            press;
  logic [1:0]      mode;
  logic [SW-1:0]   selector;
  logic [TW-1:0]   timer;
  logic [N*TW-1:0] p_time;
  logic [N-1:0]    occupied;
  logic [SW-1:0]   free_count;
  logic            done;
  logic            err;
  logic [1:0]      err_code;
  logic [SW-1:0]   slot_out;
  logic [TW-1:0]   duration;

  parking_slot_table #(.N_SLOTS(N), .TW(TW), .SEL_W(SW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .press      (press),
    .mode       (mode),
    .selector   (selector),
    .timer      (timer),
    .p_time     (p_time),
    .occupied   (occupied),
    .free_count (free_count),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .slot_out   (slot_out),
    .duration   (duration)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit      m_occ [N];
  int      m_pt  [N];
  int      m_dur;
  int      m_slot;
  int      m_code;
  bit      e_done, e_err, e_chk_slot, e_chk_dur;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_occ[k] = 0;
      m_pt[k]  = 0;
    end
    m_dur  = 0;
    m_slot = 0;
    m_code = 0;
  endtask

  // Apply one command to the model following the table's rules.
  task automatic model_apply(input bit en, input int md, input int sel, input int tm);
    int k;
    e_done = 0; e_err = 0; e_chk_slot = 0; e_chk_dur = 0;
    if (!en) return;
    if (md == 2) begin
      k = -1;
      for (int i = N - 1; i >= 0; i--) if (!m_occ[i]) k = i;
      e_chk_slot = 1;
      if (k < 0) begin
        e_err = 1; m_code = 3; m_slot = 0;
      end else begin
        e_done = 1; m_occ[k] = 1; m_pt[k] = tm; m_slot = k + 1;
      end
    end else if (sel < 1 || sel > N) begin
      e_err = 1; m_code = 0;
    end else begin
      k = sel - 1;
      e_chk_slot = 1;
      m_slot = sel;
      if (md == 0) begin
        if (m_occ[k]) begin
          e_err = 1; m_code = 1;
        end else begin
          e_done = 1; m_occ[k] = 1; m_pt[k] = tm;
        end
      end else begin
        if (!m_occ[k]) begin
          e_err = 1; m_code = 2;
        end else begin
          e_done = 1; e_chk_dur = 1;
          m_dur = (tm - m_pt[k]) % (1 << TW);
          if (m_dur < 0) m_dur += (1 << TW);
          if (md == 1) begin
            m_occ[k] = 0; m_pt[k] = 0;
          end
        end
      end
    end
  endtask

  task automatic chk_table(input string tag);
    logic [N*TW-1:0] exp_pt;
    logic [N-1:0]    exp_occ;
    int              nfree;
    exp_pt = '0; exp_occ = '0; nfree = 0;
    for (int k = 0; k < N; k++) begin
      exp_pt[k*TW +: TW] = TW'(m_pt[k]);
      exp_occ[k] = m_occ[k];
      if (!m_occ[k]) nfree++;
    end
    chk({tag, ".occupied"}, occupied, exp_occ);
    chk({tag, ".p_time"}, p_time, exp_pt);
    chk({tag, ".free_count"}, free_count, nfree);
  endtask

  // One full command: press high for one cycle, then low for one cycle.
  task automatic do_cmd(input bit en, input int md, input int sel, input int tm);
    @(negedge clk);
    enable = en; mode = 2'(md); selector = SW'(sel); timer = TW'(tm); press = 1'b1;
    model_apply(en, md, sel, tm);
    @(posedge clk); #1;
    $display("txn en=%0d mode=%0d sel=%0d timer=%0d -> done=%0d err=%0d code=%0d slot=%0d dur=%0d",
             en, md, sel, tm, done, err, err_code, slot_out, duration);
    chk("done", done, e_done);
    chk("err", err, e_err);
    if (e_err) chk("err_code", err_code, m_code);
    if (e_chk_slot) chk("slot_out", slot_out, m_slot);
    if (e_chk_dur) chk("duration", duration, m_dur);
    chk_table("post_cmd");
    @(negedge clk);
    press = 1'b0;
    timer = TW'($urandom);
    @(posedge clk); #1;
    chk("done_pulse", done, 1'b0);
    chk("err_pulse", err, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".p_time"}, p_time, 0);
    chk({tag, ".occupied"}, occupied, 0);
    chk({tag, ".free_count"}, free_count, N);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".err"}, err, 0);
    chk({tag, ".err_code"}, err_code, 0);
    chk({tag, ".slot_out"}, slot_out, 0);
    chk({tag, ".duration"}, duration, 0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; press = 1'b0; mode = 2'd0; selector = '0; timer = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk); reset = 1'b0;
    @(posedge clk);

    // Basic check-in / check-out
    do_cmd(1, 0, 3, 100);
    chk("ci3.occ_const", occupied, 6'b000100);
    chk("ci3.pt_const", p_time[2*TW +: TW], 100);
    chk("ci3.free_const", free_count, 5);
    do_cmd(1, 1, 3, 250);
    chk("co3.dur_const", duration, 150);
    chk("co3.occ_const", occupied, 0);

    // Wrap-around stay
    do_cmd(1, 0, 2, 2040);
    do_cmd(1, 3, 2, 2040);
    chk("q2.zero_stay", duration, 0);
    do_cmd(1, 1, 2, 10);
    chk("co2.wrap_const", duration, 18);

    // Auto check-in fills slots in order, then reports FULL
    for (int i = 0; i < 7; i++) do_cmd(1, 2, 0, 300 + i);
    chk("auto.full_code", err_code, 3);
    chk("auto.full_slot", slot_out, 0);
    chk("auto.free_zero", free_count, 0);

    // Rejections
    do_cmd(1, 0, 0, 5);
    do_cmd(1, 1, 7, 5);
    do_cmd(1, 0, 4, 5);
    do_cmd(1, 1, 4, 900);
    do_cmd(1, 1, 4, 900);
    do_cmd(1, 3, 4, 900);
    do_cmd(1, 0, 15, 5);

    // Edge with enable low is ignored
    do_cmd(0, 0, 4, 77);

    // Press held through reset release does not fire
    @(negedge clk); reset = 1'b1; press = 1'b1; mode = 2'd2; enable = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("held_press.done", done, 0);
    chk("held_press.occ", occupied, 0);
    @(negedge clk); press = 1'b0;
    @(posedge clk); #1;
    chk("held_press.done2", done, 0);

    // Reset coincident with an edge: reset wins
    do_cmd(1, 0, 5, 42);
    @(negedge clk); reset = 1'b1; press = 1'b1; mode = 2'd0; selector = 4'd1; timer = 11'd9;
    model_reset();
    @(posedge clk); #1;
    chk_reset_outputs("reset_edge");
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("reset_edge.no_fire", done, 0);
    chk_table("reset_edge");
    @(negedge clk); press = 1'b0;
    @(posedge clk);

    // Random traffic against the model
    for (int n = 0; n < 250; n++) begin
      int md, sel, tm;
      bit en;
      md  = $urandom_range(0, 3);
      sel = $urandom_range(0, 8);
      tm  = $urandom_range(0, (1 << TW) - 1);
      en  = ($urandom_range(0, 9) != 0);
      do_cmd(en, md, sel, tm);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_parking_slot_table
